// File: rtl/slow_clk_monitor_pkg.sv
// Shared types and default parameters for the slow-clock monitor.
// State encoding is fixed so it reads the same in waveforms and checkers.
package slow_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int          CNT_W_DEF   = 32'd21;
  localparam int unsigned TIMEOUT_DEF = 32'h0010_0000;
  localparam int          TOL_DEF     = 32'd16;
  localparam int          LOCK_N_DEF  = 32'd4;

endpackage

// File: rtl/slow_clk_monitor_sync.sv
// Three-flop synchronizer for an asynchronous slow clock, with edge strobes.
// rise_ev/fall_ev are combinational from the two oldest flops (s2, s3).
module sync_edge
  import slow_clk_monitor_pkg::*;
(
  input  logic CLK,
  input  logic reset,
  input  logic d_in,
  output logic rise_ev,
  output logic fall_ev,
  output logic level
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // shift the asynchronous input through the synchronizer chain
  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= d_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_ev = s2_r & ~s3_r;
  assign fall_ev = ~s2_r & s3_r;
  assign level   = s2_r;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock monitor: edge ticks in the CLK domain, period measurement,
// lock tracking on a stable period and stall (timeout) detection.
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int          TOL     = TOL_DEF,
  parameter int          LOCK_N  = LOCK_N_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic             timeout
);

  localparam int               MC_W      = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]  LOCK_V    = MC_W'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             rise_ev_s;
  logic             fall_ev_s;
  logic             level_unused;
  logic [CNT_W-1:0] cnt_r;
  logic [MC_W-1:0]  match_cnt_r;
  logic [MC_W-1:0]  mc_inc_s;
  logic [CNT_W:0]   diff_s;
  logic             match_s;
  state_t           state_r;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = {1'b0, a} - {1'b0, b};
    end else begin
      abs_diff = {1'b0, b} - {1'b0, a};
    end
  endfunction

  sync_edge u_sync (
    .CLK     (CLK),
    .reset   (reset),
    .d_in    (clk_in),
    .rise_ev (rise_ev_s),
    .fall_ev (fall_ev_s),
    .level   (level_unused)
  );

  // compare the running count against the last period
  always_comb begin
    diff_s   = abs_diff(cnt_r, period);
    match_s  = (diff_s <= TOL_V);
    mc_inc_s = match_cnt_r + MC_W'(1);
  end

  // cycles since the last rise event, saturating so a stall cannot wrap
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (rise_ev_s) begin
      cnt_r <= CNT_W'(1);
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // lock FSM with registered outputs; a rise event always beats a timeout
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r      <= IDLE;
      match_cnt_r  <= {MC_W{1'b0}};
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      period       <= {CNT_W{1'b0}};
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rise_tick <= rise_ev_s;
      fall_tick <= fall_ev_s;
      lock_lost <= 1'b0;
      if (rise_ev_s) begin
        timeout <= 1'b0;
        case (state_r)
          IDLE: begin
            state_r <= MEASURE;
          end
          MEASURE: begin
            state_r      <= TRACK;
            period       <= cnt_r;
            period_valid <= 1'b1;
            match_cnt_r  <= {MC_W{1'b0}};
          end
          TRACK: begin
            period <= cnt_r;
            if (match_s) begin
              match_cnt_r <= mc_inc_s;
              if (mc_inc_s >= LOCK_V) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              match_cnt_r <= {MC_W{1'b0}};
            end
          end
          LOCKED: begin
            period <= cnt_r;
            if (!match_s) begin
              state_r     <= TRACK;
              match_cnt_r <= {MC_W{1'b0}};
              locked      <= 1'b0;
              lock_lost   <= 1'b1;
            end
          end
          default: begin
            state_r     <= IDLE;
            match_cnt_r <= {MC_W{1'b0}};
            locked      <= 1'b0;
          end
        endcase
      end else if (cnt_r == TIMEOUT_V) begin
        timeout      <= 1'b1;
        state_r      <= IDLE;
        match_cnt_r  <= {MC_W{1'b0}};
        period_valid <= 1'b0;
        locked       <= 1'b0;
        lock_lost    <= (state_r == LOCKED);
      end
    end
  end

endmodule
